// File: rtl/uart_tx_seq_ctrl.sv
// Byte sequencer in front of the 8-bit UART transmitter: queues bytes in a FIFO and
// drives the TX_En_Sig / TX_Data / TX_Done_Sig handshake with an idle gap and a frame timeout.
module uart_tx_seq_ctrl #(
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   sclk,
    input  logic                   RSTn,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [7:0]             TX_Data,
    output logic                   TX_En_Sig,
    input  logic                   TX_Done_Sig
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GW      = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
    localparam int TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] ZERO_LEVEL = LW'(1'b0);
    localparam logic [LW-1:0] ONE_LEVEL  = LW'(1'b1);
    localparam logic [AW-1:0] ONE_PTR    = AW'(1'b1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_EFF - 1);
    localparam logic [GW-1:0] ONE_GAP    = GW'(1'b1);
    localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_MAX   = {TW{1'b1}};
    localparam logic [TW-1:0] ONE_TOUT   = TW'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            overflow_r;
    logic            timeout_err_r;
    logic [7:0]      tx_data_r;
    logic            tx_en_r;
    logic [TW-1:0]   tout_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic            full_s;
    logic            push_s;
    logic            pop_s;

    // full is judged on the registered level, so a pop in the same cycle never frees a slot early
    assign full_s = (level_r == FULL_LEVEL);
    assign push_s = wr_en && !full_s;
    assign pop_s  = (state_r == IDLE) && (level_r != ZERO_LEVEL);

    assign full        = full_s;
    assign level       = level_r;
    assign overflow    = overflow_r;
    assign busy        = (state_r != IDLE) || (level_r != ZERO_LEVEL);
    assign timeout_err = timeout_err_r;
    assign TX_Data     = tx_data_r;
    assign TX_En_Sig   = tx_en_r;

    // FIFO storage array
    always_ff @(posedge sclk) begin
        if (RSTn && push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge sclk) begin
        if (!RSTn) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= ZERO_LEVEL;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= wr_en && full_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + ONE_LEVEL;
                2'b01:   level_r <= level_r - ONE_LEVEL;
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame sequencer: IDLE pops, LOAD raises enable, SEND waits for Done or timeout, GAP idles
    always_ff @(posedge sclk) begin
        if (!RSTn) begin
            state_r       <= IDLE;
            tx_data_r     <= 8'h00;
            tx_en_r       <= 1'b0;
            timeout_err_r <= 1'b0;
            tout_cnt_r    <= {TW{1'b0}};
            gap_cnt_r     <= {GW{1'b0}};
        end else begin
            timeout_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        tx_data_r <= mem_r[rd_ptr_r];
                        state_r   <= LOAD;
                    end
                end
                LOAD: begin
                    tx_en_r    <= 1'b1;
                    tout_cnt_r <= {TW{1'b0}};
                    state_r    <= SEND;
                end
                SEND: begin
                    // Done has priority over a timeout landing on the same cycle
                    if (TX_Done_Sig) begin
                        tx_en_r   <= 1'b0;
                        gap_cnt_r <= {GW{1'b0}};
                        state_r   <= GAP;
                    end else if (tout_cnt_r == TOUT_LAST) begin
                        tx_en_r       <= 1'b0;
                        timeout_err_r <= 1'b1;
                        gap_cnt_r     <= {GW{1'b0}};
                        state_r       <= GAP;
                    end else if (tout_cnt_r != TOUT_MAX) begin
                        tout_cnt_r <= tout_cnt_r + ONE_TOUT;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + ONE_GAP;
                    end
                end
                default: begin
                    tx_en_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
